// File: rtl/dbg_abs_cmd_gpr.sv
// Abstract-command engine for debug Access Register commands targeting GPRs.
// Checks each command and turns it into one register-file read or write strobe.
module dbg_abs_cmd_gpr #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned GPR_ADDR_WIDTH = 5,
  parameter int unsigned TIMEOUT        = 8
) (
  input  logic                  dbg_clk,
  input  logic                  dbg_rst,
  input  logic                  cmd_valid_i,
  input  logic [15:0]           cmd_regno_i,
  input  logic                  cmd_write_i,
  input  logic                  cmd_transfer_i,
  input  logic [2:0]            cmd_aarsize_i,
  input  logic                  data0_wr_i,
  input  logic [DATA_WIDTH-1:0] data0_wdata_i,
  input  logic [2:0]            cmderr_clr_i,
  input  logic                  hart_halted_i,
  output logic [DATA_WIDTH-1:0] data0_o,
  output logic                  busy_o,
  output logic [2:0]            cmderr_o,
  output logic                  dbg_mode_valid_o,
  output logic                  dbg_mode_write_en_o,
  output logic [DATA_WIDTH-1:0] dbg_mode_write_data_o,
  output logic [15:0]           dbg_mode_gpr_addr_o,
  output logic                  dbg_mode_read_en_o,
  input  logic [DATA_WIDTH-1:0] dbg_mode_gpr_read_data_i,
  input  logic                  dbg_gpr_read_valid_i
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam int unsigned HI_W  = 16 - GPR_ADDR_WIDTH;
  localparam logic [HI_W-1:0] REGNO_HI = HI_W'(16'h1000 >> GPR_ADDR_WIDTH);
  localparam logic [2:0] AARSIZE   = (DATA_WIDTH == 64) ? 3'd3 : 3'd2;
  localparam logic [2:0] ERR_BUSY  = 3'd1;
  localparam logic [2:0] ERR_NSUP  = 3'd2;
  localparam logic [2:0] ERR_EXC   = 3'd3;
  localparam logic [2:0] ERR_HALT  = 3'd4;

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_WRITE, S_READ, S_DONE} state_t;

  state_t           state, state_n;
  logic [15:0]      regno_q, regno_n;
  logic             write_q, write_n;
  logic             xfer_q, xfer_n;
  logic [2:0]       size_q, size_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [DATA_WIDTH-1:0] data0_n, wdata_n;
  logic [2:0]       cmderr_n, err_code;
  logic             err_set;
  logic             busy_n, valid_n, wen_n, ren_n;
  logic [15:0]      addr_n;

  // State, command latch and registered outputs
  always_ff @(posedge dbg_clk or posedge dbg_rst) begin
    if (dbg_rst) begin
      state                 <= S_IDLE;
      regno_q               <= '0;
      write_q               <= 1'b0;
      xfer_q                <= 1'b0;
      size_q                <= '0;
      cnt                   <= '0;
      data0_o               <= '0;
      cmderr_o              <= '0;
      busy_o                <= 1'b0;
      dbg_mode_valid_o      <= 1'b0;
      dbg_mode_write_en_o   <= 1'b0;
      dbg_mode_read_en_o    <= 1'b0;
      dbg_mode_gpr_addr_o   <= '0;
      dbg_mode_write_data_o <= '0;
    end else begin
      state                 <= state_n;
      regno_q               <= regno_n;
      write_q               <= write_n;
      xfer_q                <= xfer_n;
      size_q                <= size_n;
      cnt                   <= cnt_n;
      data0_o               <= data0_n;
      cmderr_o              <= cmderr_n;
      busy_o                <= busy_n;
      dbg_mode_valid_o      <= valid_n;
      dbg_mode_write_en_o   <= wen_n;
      dbg_mode_read_en_o    <= ren_n;
      dbg_mode_gpr_addr_o   <= addr_n;
      dbg_mode_write_data_o <= wdata_n;
    end
  end

  // Next state, data0/cmderr update and next-cycle output values
  always_comb begin
    state_n  = state;
    regno_n  = regno_q;
    write_n  = write_q;
    xfer_n   = xfer_q;
    size_n   = size_q;
    cnt_n    = cnt;
    data0_n  = data0_o;
    cmderr_n = cmderr_o & ~cmderr_clr_i;
    err_set  = 1'b0;
    err_code = '0;

    unique case (state)
      S_IDLE: begin
        if (data0_wr_i) data0_n = data0_wdata_i;
        if (cmd_valid_i && (cmderr_o == 3'd0)) begin
          regno_n = cmd_regno_i;
          write_n = cmd_write_i;
          xfer_n  = cmd_transfer_i;
          size_n  = cmd_aarsize_i;
          state_n = S_CHECK;
        end
      end
      S_CHECK: begin
        cnt_n   = '0;
        state_n = S_DONE;
        if (!hart_halted_i) begin
          err_set  = 1'b1;
          err_code = ERR_HALT;
        end else if (xfer_q) begin
          if ((size_q != AARSIZE) || (regno_q[15:GPR_ADDR_WIDTH] != REGNO_HI)) begin
            err_set  = 1'b1;
            err_code = ERR_NSUP;
          end else if (regno_q[GPR_ADDR_WIDTH-1:0] == '0) begin
            // x0: writes are dropped, reads return zero without touching the file
            if (!write_q) data0_n = '0;
          end else begin
            state_n = write_q ? S_WRITE : S_READ;
          end
        end
      end
      S_WRITE: state_n = S_DONE;
      S_READ: begin
        if (dbg_gpr_read_valid_i) begin
          data0_n = dbg_mode_gpr_read_data_i;
          state_n = S_DONE;
        end else if (cnt == CNT_W'(TIMEOUT)) begin
          err_set  = 1'b1;
          err_code = ERR_EXC;
          state_n  = S_DONE;
        end else begin
          cnt_n = CNT_W'(cnt + 1'b1);
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    // DMI access while a command runs is flagged unless the command itself failed
    if ((state != S_IDLE) && (cmd_valid_i || data0_wr_i) && !err_set) begin
      err_set  = 1'b1;
      err_code = ERR_BUSY;
    end
    if (err_set && (cmderr_o == 3'd0)) cmderr_n = err_code;

    busy_n  = (state_n != S_IDLE);
    wen_n   = (state_n == S_WRITE);
    ren_n   = (state_n == S_READ);
    valid_n = wen_n || ren_n;
    addr_n  = valid_n ? regno_n : 16'd0;
    wdata_n = wen_n ? data0_o : '0;
  end

endmodule
